// File: rtl/lsu_pipe.sv
// lsu_pipe: sequential load/store unit for the memory stage.
//
// Accepts one load or store per request and drives a valid/ready data-memory
// bus. It returns one registered response with the load data sign- or
// zero-extended.
//
// Build option:
//   LSU_MISALIGN_SPLIT_EN - when defined, an access that crosses a BYTES
//                           boundary is split into two bus beats.
//                           When undefined, any misaligned access completes
//                           as an error with no bus traffic.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               request from the execute/memory stage (valid/ready)
//   bus_*               data-memory bus; bus_addr_o is always BYTES aligned
//   resp_*              one-cycle completion pulse with data, rd and error
//   stall_o             pipeline stall: unit busy or responding
//
// FSM states:
//   state | meaning
//   IDLE  | ready for a request
//   BEAT0 | first (or only) bus beat at the aligned address
//   BEAT1 | second beat of a boundary-crossing access
//   RESP  | response pulse

module lsu_pipe #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [4:0]            req_rd_i,
    output logic                  bus_valid_o,
    input  logic                  bus_ready_i,
    output logic                  bus_we_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    output logic [DATA_W/8-1:0]   bus_wmask_o,
    input  logic [DATA_W-1:0]     bus_rdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_W-1:0]     resp_data_o,
    output logic [4:0]            resp_rd_o,
    output logic                  resp_err_o,
    output logic                  stall_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFS_W = $clog2(BYTES);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state_q, state_d;

    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata0_q, rdata1_q;
    logic [4:0]        rd_q;

    // Request legality is decided from the live request fields so that an
    // illegal request can respond in the very next cycle.
    logic req_bad_size, req_err;
    assign req_bad_size = (DATA_W == 32) && (req_size_i == 2'd3);

`ifdef LSU_MISALIGN_SPLIT_EN
    assign req_err = req_bad_size;
`else
    logic [OFS_W-1:0] req_align_mask;
    always_comb begin
        case (req_size_i)
            2'd0:    req_align_mask = OFS_W'(3'd0);
            2'd1:    req_align_mask = OFS_W'(3'd1);
            2'd2:    req_align_mask = OFS_W'(3'd3);
            default: req_align_mask = OFS_W'(3'd7);
        endcase
    end
    assign req_err = req_bad_size | (|(req_addr_i[OFS_W-1:0] & req_align_mask));
`endif

    // Datapath derived only from the captured request.
    logic [OFS_W-1:0]     ofs_q;
    logic [ADDR_W-1:0]    aligned_addr;
    logic [2*DATA_W-1:0]  wide_wdata;
    logic [2*BYTES-1:0]   size_mask, wide_mask;
    logic [DATA_W-1:0]    ld_raw, keep_mask, ld_data;
    logic                 sign_bit;

    assign ofs_q        = addr_q[OFS_W-1:0];
    assign aligned_addr = {addr_q[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    assign wide_wdata   = {{DATA_W{1'b0}}, wdata_q} << {ofs_q, 3'b000};
    assign wide_mask    = size_mask << ofs_q;
    // Two-beat window shifted down so the addressed byte lands at bit 0.
    assign ld_raw       = DATA_W'({rdata1_q, rdata0_q} >> {ofs_q, 3'b000});

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [OFS_W+1:0] nbytes;
    logic             cross;
    assign nbytes = (OFS_W+2)'(1) << size_q;
    assign cross  = ({2'b00, ofs_q} + nbytes) > (OFS_W+2)'(BYTES);
`endif

    always_comb begin
        size_mask = '0;
        keep_mask = '1;
        sign_bit  = 1'b0;
        case (size_q)
            2'd0: begin
                size_mask = (2*BYTES)'(8'h01);
                keep_mask = DATA_W'(8'hFF);
                sign_bit  = ld_raw[7];
            end
            2'd1: begin
                size_mask = (2*BYTES)'(8'h03);
                keep_mask = DATA_W'(16'hFFFF);
                sign_bit  = ld_raw[15];
            end
            2'd2: begin
                size_mask = (2*BYTES)'(8'h0F);
                // A word is full width on a 32-bit unit: nothing to extend.
                if (DATA_W > 32) begin
                    keep_mask = DATA_W'(32'hFFFF_FFFF);
                    sign_bit  = ld_raw[31];
                end
            end
            default: begin
                size_mask = (2*BYTES)'(8'hFF);
            end
        endcase
        ld_data = (ld_raw & keep_mask) | ((sign_bit && !uns_q) ? ~keep_mask : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 5'd0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i) begin
                we_q     <= req_we_i;
                uns_q    <= req_unsigned_i;
                err_q    <= req_err;
                size_q   <= req_size_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                rd_q     <= req_rd_i;
                rdata0_q <= '0;
                rdata1_q <= '0;
            end
            if (state_q == BEAT0 && bus_ready_i) begin
                rdata0_q <= bus_rdata_i;
            end
            if (state_q == BEAT1 && bus_ready_i) begin
                rdata1_q <= bus_rdata_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        bus_valid_o  = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = '0;
        bus_wdata_o  = '0;
        bus_wmask_o  = '0;
        resp_valid_o = 1'b0;
        resp_data_o  = '0;
        resp_rd_o    = 5'd0;
        resp_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = req_err ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                bus_valid_o = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = aligned_addr;
                bus_wdata_o = we_q ? wide_wdata[DATA_W-1:0] : '0;
                bus_wmask_o = wide_mask[BYTES-1:0];
                if (bus_ready_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    state_d = cross ? BEAT1 : RESP;
`else
                    state_d = RESP;
`endif
                end
            end
            BEAT1: begin
                bus_valid_o = 1'b1;
                bus_we_o    = we_q;
                bus_addr_o  = aligned_addr + ADDR_W'(BYTES);
                bus_wdata_o = we_q ? wide_wdata[2*DATA_W-1:DATA_W] : '0;
                bus_wmask_o = wide_mask[2*BYTES-1:BYTES];
                if (bus_ready_i) begin
                    state_d = RESP;
                end
            end
            default: begin
                resp_valid_o = 1'b1;
                resp_rd_o    = rd_q;
                resp_err_o   = err_q;
                resp_data_o  = (we_q || err_q) ? '0 : ld_data;
                state_d      = IDLE;
            end
        endcase
    end

    assign stall_o = !req_ready_o || resp_valid_o;

endmodule

// File: tb/tb_lsu_pipe.sv
// Testbench for lsu_pipe (DATA_W=64). Stimulus issues directed requests and
// pushes the expected response into a scoreboard; an independent monitor
// pops and compares whenever resp_valid_o is seen.

module tb_lsu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [63:0] req_addr_i, req_wdata_i;
    logic [4:0]  req_rd_i;
    logic        bus_valid_o, bus_ready_i, bus_we_o;
    logic [63:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [7:0]  bus_wmask_o;
    logic        resp_valid_o, resp_err_o, stall_o;
    logic [63:0] resp_data_o;
    logic [4:0]  resp_rd_o;

    lsu_pipe #(.DATA_W(64), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i),
        .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i),
        .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_wmask_o(bus_wmask_o),
        .bus_rdata_i(bus_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
        .resp_rd_o(resp_rd_o), .resp_err_o(resp_err_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && resp_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=resp_valid required=none data=0x%0h", resp_data_o);
            end else begin
                e = sb.pop_front();
                chk("resp_data", resp_data_o, e.data);
                chk("resp_rd", 64'(resp_rd_o), 64'(e.rd));
                chk("resp_err", 64'(resp_err_o), 64'(e.err));
                chk("resp_latency", 64'(cyc - e.acc + 1), 64'(e.lat));
            end
        end
    end

    task automatic send_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [4:0] rd, input bit expect_resp,
                            input logic [63:0] exp_data, input logic exp_err, input int exp_lat);
        exp_t e;
        int n = 0;
        while (req_ready_o !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready_o !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=%b required=1", req_ready_o);
        end
        req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
        req_addr_i = addr; req_wdata_i = wdata; req_rd_i = rd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        if (expect_resp) begin
            e.data = exp_data; e.rd = rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    // One bus beat with `waits` stall cycles; outputs checked every cycle.
    task automatic beat(input string name, input logic [63:0] addr, input logic we,
                        input logic [63:0] wdata, input logic [7:0] mask,
                        input logic [63:0] rdata, input int waits);
        for (int i = 0; i < waits; i++) begin
            bus_ready_i = 1'b0;
            @(negedge clk);
            chk({name, "_wait_valid"}, 64'(bus_valid_o), 64'd1);
            chk({name, "_wait_addr"}, bus_addr_o, addr);
            chk({name, "_wait_wdata"}, bus_wdata_o, wdata);
            chk({name, "_wait_mask"}, 64'(bus_wmask_o), 64'(mask));
            chk({name, "_wait_ready"}, 64'(req_ready_o), 64'd0);
            chk({name, "_wait_stall"}, 64'(stall_o), 64'd1);
            @(posedge clk); #1;
        end
        bus_ready_i = 1'b1;
        bus_rdata_i = rdata;
        @(negedge clk);
        chk({name, "_valid"}, 64'(bus_valid_o), 64'd1);
        chk({name, "_we"}, 64'(bus_we_o), 64'(we));
        chk({name, "_addr"}, bus_addr_o, addr);
        chk({name, "_wdata"}, bus_wdata_o, wdata);
        chk({name, "_mask"}, 64'(bus_wmask_o), 64'(mask));
        @(posedge clk); #1;
        bus_ready_i = 1'b0;
        bus_rdata_i = '0;
    endtask

    task automatic no_bus(input string name);
        @(negedge clk);
        chk({name, "_no_bus"}, 64'(bus_valid_o), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout actual=%0d_pending required=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0;
        bus_ready_i = 0; bus_rdata_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_bus_valid", 64'(bus_valid_o), 64'd0);
        chk("rst_bus_addr", bus_addr_o, 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_data", resp_data_o, 64'd0);
        chk("rst_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // LW / LWU at offset 4
        send_req(0, 2'd2, 0, 64'h8000_0004, 0, 5'd5, 1, 64'hFFFF_FFFF_8765_4321, 0, 2);
        beat("lw", 64'h8000_0000, 0, 64'd0, 8'hF0, 64'h8765_4321_0000_0000, 0);
        drain();
        send_req(0, 2'd2, 1, 64'h8000_0004, 0, 5'd6, 1, 64'h0000_0000_8765_4321, 0, 2);
        beat("lwu", 64'h8000_0000, 0, 64'd0, 8'hF0, 64'h8765_4321_0000_0000, 0);
        drain();

        // SH at offset 6
        send_req(1, 2'd1, 0, 64'h8000_0006, 64'hABCD, 5'd7, 1, 64'd0, 0, 2);
        beat("sh", 64'h8000_0000, 1, 64'hABCD_0000_0000_0000, 8'hC0, 64'hDEAD_BEEF, 0);
        drain();

        // Aligned LD: full width returned unchanged
        send_req(0, 2'd3, 0, 64'h8000_0008, 0, 5'd8, 1, 64'h8123_4567_89AB_CDEF, 0, 2);
        beat("ld_al", 64'h8000_0008, 0, 64'd0, 8'hFF, 64'h8123_4567_89AB_CDEF, 0);
        drain();

`ifdef LSU_MISALIGN_SPLIT_EN
        send_req(0, 2'd3, 0, 64'h8000_0003, 0, 5'd9, 1, 64'hAA99_8877_6655_4433, 0, 3);
        beat("ld_b0", 64'h8000_0000, 0, 64'd0, 8'hF8, 64'h7766_5544_3322_1100, 0);
        beat("ld_b1", 64'h8000_0008, 0, 64'd0, 8'h07, 64'hFFEE_DDCC_BBAA_9988, 0);
        drain();
        send_req(1, 2'd2, 0, 64'h8000_0006, 64'h1122_3344, 5'd10, 1, 64'd0, 0, 3);
        beat("sw_b0", 64'h8000_0000, 1, 64'h3344_0000_0000_0000, 8'hC0, 64'd0, 0);
        beat("sw_b1", 64'h8000_0008, 1, 64'h0000_0000_0000_1122, 8'h03, 64'd0, 0);
        drain();
        send_req(0, 2'd1, 1, 64'h8000_0001, 0, 5'd11, 1, 64'h0000_0000_0000_BEEF, 0, 2);
        beat("lhu_mis", 64'h8000_0000, 0, 64'd0, 8'h06, 64'h0000_0000_00BE_EF00, 0);
        drain();
`else
        send_req(0, 2'd3, 0, 64'h8000_0003, 0, 5'd9, 1, 64'd0, 1, 1);
        no_bus("ld_mis");
        drain();
        send_req(1, 2'd2, 0, 64'h8000_0006, 64'h1122_3344, 5'd10, 1, 64'd0, 1, 1);
        no_bus("sw_mis");
        drain();
        send_req(0, 2'd1, 1, 64'h8000_0001, 0, 5'd11, 1, 64'd0, 1, 1);
        no_bus("lhu_mis");
        drain();
`endif

        // LH with 5 wait states
        send_req(0, 2'd1, 0, 64'h8000_0002, 0, 5'd12, 1, 64'hFFFF_FFFF_FFFF_8001, 0, 7);
        beat("lh_wait", 64'h8000_0000, 0, 64'd0, 8'h0C, 64'h0000_0000_8001_0000, 5);
        drain();

        // Reset in BEAT0 abandons the access
        send_req(0, 2'd3, 0, 64'h8000_0010, 0, 5'd13, 0, 64'd0, 0, 0);
        @(negedge clk);
        chk("abort_beat0_valid", 64'(bus_valid_o), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_bus_valid", 64'(bus_valid_o), 64'd0);
        chk("abort_req_ready", 64'(req_ready_o), 64'd1);
        chk("abort_resp_valid", 64'(resp_valid_o), 64'd0);
        send_req(0, 2'd0, 0, 64'h8000_0001, 0, 5'd14, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 2);
        beat("lb_after", 64'h8000_0000, 0, 64'd0, 8'h02, 64'h0000_0000_0000_8000, 0);
        drain();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_pipe.md
# lsu_pipe

Parametrised, sequential load/store unit that replaces the combinational memory-stage datapath. It accepts one load or store per request from the execute/memory pipeline stage. It drives a valid/ready data-memory bus and returns a single registered response with sign- or zero-extended load data. It adds width parametrisation, an explicit request/response handshake and optional splitting of misaligned accesses into two bus beats.

## Interface
Parameters:
- DATA_W, 64, bus and register width; legal values 32 or 64. BYTES = DATA_W/8, OFS_W = log2(BYTES).
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit idle; request accepted on req_valid_i && req_ready_o.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 byte, 1 half, 2 word, 3 double.
- req_unsigned_i  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data, right-aligned.
- req_rd_i  in  5  destination register, echoed on the response.
- bus_valid_o  out  1  bus transaction pending.
- bus_ready_i  in  1  transaction completes this cycle; bus_rdata_i is valid in the same cycle.
- bus_we_o  out  1  write strobe.
- bus_addr_o  out  ADDR_W  address, aligned to BYTES (low OFS_W bits zero).
- bus_wdata_o  out  DATA_W  lane-shifted store data.
- bus_wmask_o  out  BYTES  byte-enable mask.
- bus_rdata_i  in  DATA_W  read data.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_data_o  out  DATA_W  extended load data; 0 for stores and errors.
- resp_rd_o  out  5  echoed req_rd_i.
- resp_err_o  out  1  misaligned access when splitting is not supported, or size 3 with DATA_W=32.
- stall_o  out  1  equal to !req_ready_o || resp_valid_o.

## Operation
- FSM states: IDLE, BEAT0, BEAT1, RESP. Reset state is IDLE.
- Request fields are captured into registers on acceptance. Outputs depend only on the registers.
- IDLE:
  - An accepted legal request goes to BEAT0.
  - An accepted illegal request goes to RESP with resp_err_o=1. No bus transaction is issued.
- BEAT0:
  - bus_addr_o = addr with the low OFS_W bits cleared.
  - bus_valid_o=1 until bus_ready_i.
  - On bus_ready_i: go to BEAT1 if the access crosses a BYTES boundary (offset + 2^size > BYTES), otherwise go to RESP.
  - bus_rdata_i is latched at the handshake.
- BEAT1:
  - bus_addr_o = aligned addr + BYTES.
  - Mask carries the remaining high bytes.
  - On bus_ready_i, go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, then return to IDLE.
- Store lanes:
  - Beat 0: wdata = req_wdata << 8·offset, mask = ((1<<2^size)−1) << offset. Both are truncated to DATA_W and BYTES.
  - Beat 1: wdata = req_wdata >> 8·(BYTES−offset), mask = mask bits shifted out of beat 0.
- Loads:
  - Concatenate {beat1, beat0} and shift right by 8·offset.
  - Take the low 2^size bytes.
  - Sign- or zero-extend to DATA_W.
  - For size 3, or size 2 when DATA_W=32, the full width is returned unchanged.
- Bus outputs are 0 when bus_valid_o=0.
- Address, data, mask and we stay stable while bus_valid_o=1 && !bus_ready_i.

## Timing
- All outputs reset to 0, except req_ready_o, which is 1 one cycle after rst is sampled high.
- Aligned access with zero-wait bus:
  - Accept at edge E0.
  - bus_valid_o is high in cycle E0→E1.
  - resp_valid_o is high in cycle E1→E2.
  - Latency is 2 cycles.
- Each wait cycle on bus_ready_i adds 1 cycle. A split access adds at least 1 cycle.
- Error response: resp_valid_o is high in cycle E0→E1 (latency 1).
- rst high in any state, including mid-beat: next edge returns to IDLE and drops bus_valid_o without completing the transaction. No response is produced.
- No new request is accepted while busy or in RESP; a new request is accepted only in IDLE.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined:
  - A boundary-crossing access performs two beats (BEAT0, BEAT1).
  - Misalignment that does not cross a boundary completes in one beat.
- Not defined:
  - Any address with offset not a multiple of 2^size is an error: no bus traffic, resp_err_o=1.
  - BEAT1 does not exist.
- The illegal-size error is present in both builds.

## Test plan
All scenarios use DATA_W=64.
- LW at 0x80000004, bus_rdata_i=0x8765432100000000, zero-wait -> resp_data_o=0xFFFFFFFF87654321 at latency 2; the same access as LWU -> 0x0000000087654321.
- SH at 0x80000006, wdata=0xABCD -> bus_wdata_o=0xABCD000000000000, bus_wmask_o=0xC0, bus_addr_o=0x80000000, resp_data_o=0.
- With macro: LD at 0x80000003, rdata0=0x7766554433221100 at 0x80000000, rdata1=0xFFEEDDCCBBAA9988 at 0x80000008 -> resp_data_o=0xAA99887766554433. Without macro: no bus_valid_o, resp_err_o=1 at latency 1.
- With macro: SW at 0x80000006, wdata=0x11223344 -> beat 0 wdata 0x3344000000000000, mask 0xC0; beat 1 addr 0x80000008, wdata 0x1122, mask 0x03.
- bus_ready_i held low 5 cycles on a load -> bus outputs stable, req_ready_o=0, stall_o=1, resp latency 7.
- rst pulsed in BEAT0 -> next cycle bus_valid_o=0, req_ready_o=1, no resp_valid_o; a following aligned LB completes normally.
